uart_ctrl: RTL

Bus-side controller for one UART channel. Buffers bytes delivered by the UART receiver (`rx_end`/`rx_data` pulse interface) in a small RX FIFO, sequences the UART transmitter through a one-byte holding register, and exposes both through a three-register slave port with a maskable interrupt. Sits between the system bus slave decoder and the `uart_rx`/`uart_tx` datapaths, replacing direct CPU polling of those blocks.

---
 rtl/uart_ctrl_if.sv | 23 ++
 rtl/uart_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_if.sv
// Bus-side slave port of the UART controller: single-cycle strobed
// register accesses, registered read data with a ready pulse, and the
// level interrupt.
interface uart_ctrl_if;
  logic        cs;
  logic        as;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy;
  logic        irq;

  modport master (
    output cs, as, rw, addr, wr_data,
    input  rd_data, rdy, irq
  );

  modport slave (
    input  cs, as, rw, addr, wr_data,
    output rd_data, rdy, irq
  );
endinterface

// File: rtl/uart_ctrl.sv
// UART channel controller: buffers received bytes in a small FIFO, feeds
// the transmitter through a one-byte holding register, and exposes
// STATUS / DATA / IE registers plus a maskable level interrupt.
module uart_ctrl #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  input  logic        rx_end,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_end
);

  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(RX_DEPTH);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_IE     = 2'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_SEND  = 2'd2
  } tx_state_t;

  tx_state_t        state_reg, state_next;

  logic [7:0]       fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   cnt_reg, cnt_next;

  logic             rx_int_reg, tx_int_reg, overrun_reg;
  logic             rx_int_next, tx_int_next, overrun_next;
  logic [1:0]       ie_reg;
  logic [7:0]       hold_reg;
  logic             hold_full_reg;
  logic [7:0]       tx_data_reg;
  logic [31:0]      rd_data_reg, rd_data_next;
  logic             rdy_reg;

  logic             access, rd_acc, wr_acc;
  logic             data_rd, data_wr, status_wr, ie_wr;
  logic             fifo_empty, fifo_full;
  logic             pop, push, overrun_set;
  logic             tx_done;
  logic [7:0]       head_byte;
  logic [31:0]      status_word;
  logic             unused_wr_bits;

  // Only the low byte of write data carries register content.
  assign unused_wr_bits = ^bus.wr_data[31:8];

  assign access    = bus.cs & bus.as;
  assign rd_acc    = access & bus.rw;
  assign wr_acc    = access & ~bus.rw;
  assign data_rd   = rd_acc & (bus.addr == ADDR_DATA);
  assign data_wr   = wr_acc & (bus.addr == ADDR_DATA);
  assign status_wr = wr_acc & (bus.addr == ADDR_STATUS);
  assign ie_wr     = wr_acc & (bus.addr == ADDR_IE);

  assign fifo_empty = (cnt_reg == '0);
  assign fifo_full  = (cnt_reg == DEPTH_CNT);

  // A read of an empty FIFO is not a pop; a read frees a slot for a
  // simultaneous push even when the FIFO is full.
  assign pop         = data_rd & ~fifo_empty;
  assign push        = rx_end & (~fifo_full | pop);
  assign overrun_set = rx_end & fifo_full & ~pop;
  assign tx_done     = (state_reg == TX_SEND) & tx_end;

  assign head_byte = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];

  assign status_word = {25'd0, (state_reg != TX_IDLE), hold_full_reg,
                        overrun_reg, fifo_full, fifo_empty,
                        tx_int_reg, rx_int_reg};

  assign bus.rd_data = rd_data_reg;
  assign bus.rdy     = rdy_reg;
  assign bus.irq     = (rx_int_reg & ie_reg[0]) | (tx_int_reg & ie_reg[1]);
  assign tx_data     = tx_data_reg;

  // FIFO storage: plain array, no reset, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= rx_data;
    end
  end

  // FIFO occupancy after this cycle's push/pop pair.
  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + (PTR_W+1)'(1);
      2'b01:   cnt_next = cnt_reg - (PTR_W+1)'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  // FIFO pointers and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      cnt_reg <= cnt_next;
    end
  end

  // Sticky status bits: write-one-to-clear, with a same-cycle set winning.
  always_comb begin
    rx_int_next  = rx_int_reg;
    tx_int_next  = tx_int_reg;
    overrun_next = overrun_reg;
    if (status_wr && bus.wr_data[0]) rx_int_next  = 1'b0;
    if (status_wr && bus.wr_data[1]) tx_int_next  = 1'b0;
    if (status_wr && bus.wr_data[4]) overrun_next = 1'b0;
    if (rx_end)      rx_int_next  = 1'b1;
    if (tx_done)     tx_int_next  = 1'b1;
    if (overrun_set) overrun_next = 1'b1;
  end

  // Sticky bits, interrupt enables and the TX holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_int_reg    <= 1'b0;
      tx_int_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
      ie_reg        <= 2'b00;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
    end else begin
      rx_int_reg  <= rx_int_next;
      tx_int_reg  <= tx_int_next;
      overrun_reg <= overrun_next;
      if (ie_wr) ie_reg <= bus.wr_data[1:0];
      // The hold is still full during START, so a write there is dropped.
      if (state_reg == TX_START) begin
        hold_full_reg <= 1'b0;
      end else if (data_wr && !hold_full_reg) begin
        hold_reg      <= bus.wr_data[7:0];
        hold_full_reg <= 1'b1;
      end
    end
  end

  // Read mux: value presented on the cycle after the access.
  always_comb begin
    rd_data_next = 32'd0;
    if (rd_acc) begin
      case (bus.addr)
        ADDR_STATUS: rd_data_next = status_word;
        ADDR_DATA:   rd_data_next = {24'd0, head_byte};
        ADDR_IE:     rd_data_next = {30'd0, ie_reg};
        default:     rd_data_next = 32'd0;
      endcase
    end
  end

  // Registered read data and access-complete pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= 32'd0;
      rdy_reg     <= 1'b0;
    end else begin
      rd_data_reg <= rd_data_next;
      rdy_reg     <= access;
    end
  end

  // TX sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= TX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // TX sequencer next state and start strobe.
  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        if (hold_full_reg && !tx_busy) state_next = TX_START;
      end
      TX_START: begin
        tx_start   = 1'b1;
        state_next = TX_SEND;
      end
      TX_SEND: begin
        if (tx_end) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // Launched byte: loaded on entry to START and held until the next launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_reg <= 8'h00;
    end else if (state_reg == TX_IDLE && state_next == TX_START) begin
      tx_data_reg <= hold_reg;
    end
  end

endmodule
